// File: rtl/data_memory_be.sv
// Byte-addressed data memory for the MEM stage: byte/half/word stores with lane
// merging, sign/zero-extended loads, misalignment detection, 1- or 2-cycle read latency.
module data_memory_be #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       WriteData_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [31:0]       ReadData_o,
  output logic              rvalid_o,
  output logic              misalign_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             misaligned;
  logic             store_en;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      old_word;
  logic [31:0]      merged_word;
  logic [31:0]      shifted_word;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  assign word_idx = addr_i[IDX_W+1:2];
  assign lane     = addr_i[1:0];

  // Upper address bits only select aliases of the same word (wrap-around).
  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  always_comb begin
    misaligned = 1'b1;
    byte_en    = 4'b0000;
    wdata_rep  = WriteData_i;
    case (size_i)
      2'b00: begin
        misaligned = 1'b0;
        byte_en    = 4'b0001 << lane;
        wdata_rep  = {4{WriteData_i[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{WriteData_i[15:0]}};
      end
      2'b10: begin
        misaligned = (lane != 2'b00);
        byte_en    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign store_en = MemWrite_i & ~misaligned;
  assign old_word = mem[word_idx];

  // The post-store word feeds both the array and the load path, so a combined
  // read+write returns merged data in the same cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = (store_en && byte_en[gi]) ? wdata_rep[gi*8 +: 8]
                                                                 : old_word[gi*8 +: 8];
    end
  endgenerate

  // Contents are deliberately not reset; a request sampled during reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && store_en) begin
      mem[word_idx] <= merged_word;
    end
  end

  assign shifted_word = merged_word >> {lane, 3'b000};
  assign half_sel     = lane[1] ? merged_word[31:16] : merged_word[15:0];

  always_comb begin
    load_data = 32'h0;
    if (!misaligned) begin
      case (size_i)
        2'b00:   load_data = {{24{~unsigned_i & shifted_word[7]}}, shifted_word[7:0]};
        2'b01:   load_data = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        2'b10:   load_data = merged_word;
        default: load_data = 32'h0;
      endcase
    end
  end

  logic        s1_valid_reg;
  logic        s1_mis_reg;
  logic [31:0] s1_data_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_reg <= 1'b0;
      s1_mis_reg   <= 1'b0;
      s1_data_reg  <= 32'h0;
    end else begin
      s1_valid_reg <= MemRead_i;
      s1_mis_reg   <= (MemRead_i | MemWrite_i) & misaligned;
      if (MemRead_i) begin
        s1_data_reg <= load_data;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        s2_valid_reg;
      logic        s2_mis_reg;
      logic [31:0] s2_data_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s2_valid_reg <= 1'b0;
          s2_mis_reg   <= 1'b0;
          s2_data_reg  <= 32'h0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          s2_mis_reg   <= s1_mis_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign ReadData_o = s2_data_reg;
      assign rvalid_o   = s2_valid_reg;
      assign misalign_o = s2_mis_reg;
    end else begin : g_lat1
      assign ReadData_o = s1_data_reg;
      assign rvalid_o   = s1_valid_reg;
      assign misalign_o = s1_mis_reg;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench: one instance per read latency, sharing stimulus; each result is
// checked on the latency-1 copy one edge after the request and on the latency-2 copy one edge later.
module tb_data_memory_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] rdata1, rdata2;
  logic        rv1, rv2, mis1, mis2;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  data_memory_be #(.DEPTH(32), .ADDR_W(32), .READ_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .WriteData_i(wdata),
    .MemRead_i(rd), .MemWrite_i(wr), .size_i(size), .unsigned_i(uns),
    .ReadData_o(rdata1), .rvalid_o(rv1), .misalign_o(mis1)
  );

  data_memory_be #(.DEPTH(32), .ADDR_W(32), .READ_LAT(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .WriteData_i(wdata),
    .MemRead_i(rd), .MemWrite_i(wr), .size_i(size), .unsigned_i(uns),
    .ReadData_o(rdata2), .rvalid_o(rv2), .misalign_o(mis2)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        rv;
    logic        mis;
    logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] s, input logic u,
                              input logic erv, input logic emis, input logic [31:0] edata);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.size = s; v.uns = u;
    v.rv = erv; v.mis = emis; v.data = edata;
    return v;
  endfunction

  // Applies one request for exactly one clock edge; returns 1 time unit after that edge.
  task automatic drive(input vec_t v);
    @(negedge clk);
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata; size = v.size; uns = v.uns;
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    $display("xact rd=%0b wr=%0b size=%0d uns=%0b addr=%h wdata=%h -> lat1 rv=%0b mis=%0b data=%h",
             v.rd, v.wr, v.size, v.uns, v.addr, v.wdata, rv1, mis1, rdata1);
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'd2; uns = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({rv1, mis1, rdata1} !== 34'h0) begin
      nerr++;
      $display("FAIL reset lat1: got rv=%0b mis=%0b data=%h, want all zero", rv1, mis1, rdata1);
    end
    nchk++;
    if ({rv2, mis2, rdata2} !== 34'h0) begin
      nerr++;
      $display("FAIL reset lat2: got rv=%0b mis=%0b data=%h, want all zero", rv2, mis2, rdata2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    vec_t v[2];
    v[0] = mk(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
    v[1] = mk(1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    foreach (v[i]) begin
      drive(v[i]);
      nchk++;
      if ({rv1, mis1, rdata1} !== {v[i].rv, v[i].mis, v[i].data}) begin
        nerr++;
        $display("FAIL word[%0d] lat1: got rv=%0b mis=%0b data=%h, want rv=%0b mis=%0b data=%h",
                 i, rv1, mis1, rdata1, v[i].rv, v[i].mis, v[i].data);
      end
      @(posedge clk);
      #1;
      nchk++;
      if ({rv2, mis2, rdata2, rv1} !== {v[i].rv, v[i].mis, v[i].data, 1'b0}) begin
        nerr++;
        $display("FAIL word[%0d] lat2: got rv=%0b mis=%0b data=%h lat1_rv=%0b, want rv=%0b mis=%0b data=%h lat1_rv=0",
                 i, rv2, mis2, rdata2, rv1, v[i].rv, v[i].mis, v[i].data);
      end
    end
  endtask

  task automatic test_byte();
    vec_t v[7];
    v[0] = mk(1'b0, 1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    v[1] = mk(1'b0, 1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    v[2] = mk(1'b1, 1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80);
    v[3] = mk(1'b1, 1'b0, 32'h13, 32'h0,        2'd0, 1'b1, 1'b1, 1'b0, 32'h00000080);
    v[4] = mk(1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b1, 1'b1, 1'b0, 32'h80223344);
    v[5] = mk(1'b1, 1'b0, 32'h10, 32'h0,        2'd0, 1'b0, 1'b1, 1'b0, 32'h00000044);
    v[6] = mk(1'b1, 1'b0, 32'h12, 32'h0,        2'd1, 1'b0, 1'b1, 1'b0, 32'hFFFF8022);
    foreach (v[i]) begin
      drive(v[i]);
      nchk++;
      if ({rv1, mis1, rdata1} !== {v[i].rv, v[i].mis, v[i].data}) begin
        nerr++;
        $display("FAIL byte[%0d] lat1: got rv=%0b mis=%0b data=%h, want rv=%0b mis=%0b data=%h",
                 i, rv1, mis1, rdata1, v[i].rv, v[i].mis, v[i].data);
      end
      @(posedge clk);
      #1;
      nchk++;
      if ({rv2, mis2, rdata2} !== {v[i].rv, v[i].mis, v[i].data}) begin
        nerr++;
        $display("FAIL byte[%0d] lat2: got rv=%0b mis=%0b data=%h, want rv=%0b mis=%0b data=%h",
                 i, rv2, mis2, rdata2, v[i].rv, v[i].mis, v[i].data);
      end
    end
  endtask

  task automatic test_half_misalign();
    vec_t v[11];
    v[0]  = mk(1'b0, 1'b1, 32'h10, 32'h0,        2'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF8022);
    v[1]  = mk(1'b0, 1'b1, 32'h12, 32'h0000BEEF, 2'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF8022);
    v[2]  = mk(1'b1, 1'b0, 32'h12, 32'h0,        2'd1, 1'b0, 1'b1, 1'b0, 32'hFFFFBEEF);
    v[3]  = mk(1'b1, 1'b0, 32'h12, 32'h0,        2'd1, 1'b1, 1'b1, 1'b0, 32'h0000BEEF);
    v[4]  = mk(1'b0, 1'b1, 32'h11, 32'h00001234, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0000BEEF);
    v[5]  = mk(1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 32'hBEEF0000);
    v[6]  = mk(1'b1, 1'b0, 32'h02, 32'h0,        2'd2, 1'b0, 1'b1, 1'b1, 32'h0);
    v[7]  = mk(1'b1, 1'b0, 32'h00, 32'h0,        2'd3, 1'b0, 1'b1, 1'b1, 32'h0);
    v[8]  = mk(1'b0, 1'b0, 32'h03, 32'h0,        2'd3, 1'b0, 1'b0, 1'b0, 32'h0);
    v[9]  = mk(1'b0, 1'b1, 32'h13, 32'h00000001, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0);
    v[10] = mk(1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 32'hBEEF0000);
    foreach (v[i]) begin
      drive(v[i]);
      nchk++;
      if ({rv1, mis1, rdata1} !== {v[i].rv, v[i].mis, v[i].data}) begin
        nerr++;
        $display("FAIL half[%0d] lat1: got rv=%0b mis=%0b data=%h, want rv=%0b mis=%0b data=%h",
                 i, rv1, mis1, rdata1, v[i].rv, v[i].mis, v[i].data);
      end
      @(posedge clk);
      #1;
      nchk++;
      if ({rv2, mis2, rdata2} !== {v[i].rv, v[i].mis, v[i].data}) begin
        nerr++;
        $display("FAIL half[%0d] lat2: got rv=%0b mis=%0b data=%h, want rv=%0b mis=%0b data=%h",
                 i, rv2, mis2, rdata2, v[i].rv, v[i].mis, v[i].data);
      end
    end
  endtask

  task automatic test_rw_wrap();
    vec_t v[6];
    v[0] = mk(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 2'd2, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
    v[1] = mk(1'b1, 1'b0, 32'hA0, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
    v[2] = mk(1'b1, 1'b1, 32'h21, 32'h0000005A, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0000005A);
    v[3] = mk(1'b1, 1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 32'hCAFE5A0D);
    v[4] = mk(1'b1, 1'b1, 32'h22, 32'h0,        2'd2, 1'b0, 1'b1, 1'b1, 32'h0);
    v[5] = mk(1'b1, 1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 1'b1, 1'b0, 32'hCAFE5A0D);
    foreach (v[i]) begin
      drive(v[i]);
      nchk++;
      if ({rv1, mis1, rdata1} !== {v[i].rv, v[i].mis, v[i].data}) begin
        nerr++;
        $display("FAIL rw[%0d] lat1: got rv=%0b mis=%0b data=%h, want rv=%0b mis=%0b data=%h",
                 i, rv1, mis1, rdata1, v[i].rv, v[i].mis, v[i].data);
      end
      @(posedge clk);
      #1;
      nchk++;
      if ({rv2, mis2, rdata2} !== {v[i].rv, v[i].mis, v[i].data}) begin
        nerr++;
        $display("FAIL rw[%0d] lat2: got rv=%0b mis=%0b data=%h, want rv=%0b mis=%0b data=%h",
                 i, rv2, mis2, rdata2, v[i].rv, v[i].mis, v[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] val [4];
    val[0] = 32'h11111111; val[1] = 32'h22222222; val[2] = 32'h33333333; val[3] = 32'h44444444;
    for (int k = 0; k < 4; k++) begin
      drive(mk(1'b0, 1'b1, 32'(4 * k), val[k], 2'd2, 1'b0, 1'b0, 1'b0, 32'h0));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rd = 1'b1; wr = 1'b0; addr = 32'(4 * k); size = 2'd2; uns = 1'b0;
      @(posedge clk);
      #1;
      $display("xact b2b load addr=%h -> lat1 rv=%0b data=%h lat2 rv=%0b data=%h",
               addr, rv1, rdata1, rv2, rdata2);
      nchk++;
      if ({rv1, mis1, rdata1} !== {1'b1, 1'b0, val[k]}) begin
        nerr++;
        $display("FAIL b2b[%0d] lat1: got rv=%0b mis=%0b data=%h, want rv=1 mis=0 data=%h",
                 k, rv1, mis1, rdata1, val[k]);
      end
      nchk++;
      if (k == 0) begin
        if ({rv2, mis2, rdata2} !== {1'b0, 1'b0, 32'hCAFE5A0D}) begin
          nerr++;
          $display("FAIL b2b[0] lat2 early: got rv=%0b mis=%0b data=%h, want rv=0 mis=0 data=cafe5a0d",
                   rv2, mis2, rdata2);
        end
      end else if ({rv2, mis2, rdata2} !== {1'b1, 1'b0, val[k-1]}) begin
        nerr++;
        $display("FAIL b2b[%0d] lat2: got rv=%0b mis=%0b data=%h, want rv=1 mis=0 data=%h",
                 k, rv2, mis2, rdata2, val[k-1]);
      end
    end
    rd = 1'b0;
    @(posedge clk);
    #1;
    nchk++;
    if ({rv2, rdata2, rv1, rdata1} !== {1'b1, val[3], 1'b0, val[3]}) begin
      nerr++;
      $display("FAIL b2b tail: got lat2 rv=%0b data=%h lat1 rv=%0b data=%h, want lat2 rv=1 lat1 rv=0 data=%h",
               rv2, rdata2, rv1, rdata1, val[3]);
    end
    @(posedge clk);
    #1;
    nchk++;
    if (rv2 !== 1'b0) begin
      nerr++;
      $display("FAIL b2b end: got lat2 rv=%0b, want 0", rv2);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = 32'h4; size = 2'd2; uns = 1'b0;
    @(posedge clk);
    #1;
    rd = 1'b0;
    rst = 1'b1;
    #1;
    nchk++;
    if ({rv1, mis1, rdata1, rv2, mis2, rdata2} !== 68'h0) begin
      nerr++;
      $display("FAIL rst_async: got lat1 rv=%0b data=%h lat2 rv=%0b data=%h, want all zero",
               rv1, rdata1, rv2, rdata2);
    end
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = 32'h4; wdata = 32'hFFFFFFFF; size = 2'd2;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    @(posedge clk);
    #1;
    $display("xact reset hold -> lat1 rv=%0b data=%h lat2 rv=%0b data=%h", rv1, rdata1, rv2, rdata2);
    nchk++;
    if ({rv1, mis1, rdata1, rv2, mis2, rdata2} !== 68'h0) begin
      nerr++;
      $display("FAIL rst_hold: got lat1 rv=%0b data=%h lat2 rv=%0b mis=%0b data=%h, want all zero",
               rv1, rdata1, rv2, mis2, rdata2);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(mk(1'b1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h22222222));
    nchk++;
    if ({rv1, mis1, rdata1} !== {1'b1, 1'b0, 32'h22222222}) begin
      nerr++;
      $display("FAIL rst_retain lat1: got rv=%0b mis=%0b data=%h, want rv=1 mis=0 data=22222222",
               rv1, mis1, rdata1);
    end
    @(posedge clk);
    #1;
    nchk++;
    if ({rv2, mis2, rdata2} !== {1'b1, 1'b0, 32'h22222222}) begin
      nerr++;
      $display("FAIL rst_retain lat2: got rv=%0b mis=%0b data=%h, want rv=1 mis=0 data=22222222",
               rv2, mis2, rdata2);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_misalign();
    test_rw_wrap();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
